hs_rx_responder: RTL

//  Receiving end of the 4-phase req/ack bundled-data channel that carries

---
 rtl/hs_rx_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hs_rx_responder.sv
// hs_rx_responder
//   Receive side of a 4-phase req/ack bundled-data channel crossing into
//   this clock domain. The incoming req is synchronised, the bundled data
//   is captured once req is seen high, and the word is offered on a
//   valid/ready stream. ack is raised only when the consumer takes the
//   word, so downstream backpressure stalls the sender.
//
// Ports
//   clk        destination-domain clock (rising edge)
//   rst        asynchronous active-low reset
//   req        request from sender (asynchronous to clk)
//   data       bundled data, stable while req is high
//   ack        registered acknowledge back to the sender
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts the word while out_valid is high
//   out_data   captured word
//   xfer_cnt   number of accepted words, wraps
//   err        sticky flag: req dropped before the word was accepted
module hs_rx_responder #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] data,
    output logic             ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_s;
    logic                 ack_q, ack_d;
    logic                 vld_q, vld_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    // req synchroniser; only its last stage is used by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        vld_d   = vld_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            // Arm only from IDLE, which is reached once req_s has dropped,
            // so a held req never produces a second capture.
            IDLE: begin
                if (req_s) begin
                    data_d  = data;
                    vld_d   = 1'b1;
                    state_d = VALID;
                end
            end
            // A dropped req here is a sender violation; flag it but still
            // deliver the word. Acceptance may coincide with the violation.
            VALID: begin
                if (!req_s) err_d = 1'b1;
                if (vld_q && out_ready) begin
                    vld_d   = 1'b0;
                    ack_d   = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ack       = ack_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign xfer_cnt  = cnt_q;
    assign err       = err_q;

endmodule
